mem_access_arbiter: RTL

- Clocked round-robin scheduler that shares one single-port-pair neuron/weight memory between NREQ requesters (PEs in the SNN array).
- Each requester issues one read or write at a time. The arbiter serialises requests onto the memory write channel (addr+data) or read channel (addr -> data) and returns a response to the winner.
- Sits between the PE cluster and the shared memory. Exactly one transaction is outstanding at the memory at any time.

---
 rtl/mem_access_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one memory write channel and one read channel among NREQ requesters.
// Define MEM_ARB_WDT_EN to enable the read-data watchdog (TIMEOUT cycles in RD_WAIT).
module mem_access_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 2,
    parameter int DW      = 8,
    parameter int DEPTH   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [DW-1:0]        rsp_data,
    output logic                 rsp_err,
    output logic                 mem_wr_valid,
    input  logic                 mem_wr_ready,
    output logic [AW-1:0]        mem_wr_addr,
    output logic [DW-1:0]        mem_wr_data,
    output logic                 mem_rd_valid,
    input  logic                 mem_rd_ready,
    output logic [AW-1:0]        mem_rd_addr,
    input  logic                 mem_rdata_valid,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
`ifdef MEM_ARB_WDT_EN
    localparam bit WDT_EN = 1'b1;
`else
    localparam bit WDT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CW-1:0]   wdt_cnt_q, wdt_cnt_d;

    logic            found_s;
    logic [IW-1:0]   pick_s;
    logic [IW-1:0]   idx_s;
    logic [AW-1:0]   cap_addr_s;
    logic            wdt_expired_s;

    // Round-robin search: first valid requester at or above rr_ptr_q, wrapping at NREQ
    always_comb begin
        found_s = 1'b0;
        pick_s  = {IW{1'b0}};
        idx_s   = {IW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx_s = IW'((int'(rr_ptr_q) + k) % NREQ);
            if (!found_s && req_valid[idx_s]) begin
                found_s = 1'b1;
                pick_s  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign cap_addr_s    = req_addr[pick_s*AW +: AW];
    assign wdt_expired_s = WDT_EN && (wdt_cnt_q == CW'(TIMEOUT - 1));

    // Next-state, capture and response-field logic
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        wdt_cnt_d = {CW{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    gnt_d    = pick_s;
                    we_d     = req_we[pick_s];
                    addr_d   = cap_addr_s;
                    wdata_d  = req_wdata[pick_s*DW +: DW];
                    rdata_d  = {DW{1'b0}};
                    rr_ptr_d = (pick_s == IW'(NREQ - 1)) ? {IW{1'b0}} : pick_s + IW'(1);
                    if (32'(cap_addr_s) >= 32'(DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (req_we[pick_s]) begin
                        err_d   = 1'b0;
                        state_d = ST_WR;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_RD_ADDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                if (mem_wr_ready) state_d = ST_RESP;
                else              state_d = ST_WR;
            end
            ST_RD_ADDR: begin
                if (mem_rd_ready) state_d = ST_RD_WAIT;
                else              state_d = ST_RD_ADDR;
            end
            ST_RD_WAIT: begin
                if (mem_rdata_valid) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end else if (wdt_expired_s) begin
                    rdata_d = {DW{1'b0}};
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wdt_cnt_d = wdt_cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready[gnt_q]) state_d = ST_IDLE;
                else                  state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; req_ready is forced low while reset is asserted
    always_comb begin
        req_ready    = {NREQ{1'b0}};
        rsp_valid    = {NREQ{1'b0}};
        rsp_data     = {DW{1'b0}};
        rsp_err      = 1'b0;
        mem_wr_valid = 1'b0;
        mem_wr_addr  = {AW{1'b0}};
        mem_wr_data  = {DW{1'b0}};
        mem_rd_valid = 1'b0;
        mem_rd_addr  = {AW{1'b0}};
        busy         = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (rst_n && found_s) req_ready[pick_s] = 1'b1;
                else                  req_ready = {NREQ{1'b0}};
            end
            ST_WR: begin
                mem_wr_valid = 1'b1;
                mem_wr_addr  = addr_q;
                mem_wr_data  = wdata_q;
            end
            ST_RD_ADDR: begin
                mem_rd_valid = 1'b1;
                mem_rd_addr  = addr_q;
            end
            ST_RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                rsp_data         = rdata_q;
                rsp_err          = err_q;
            end
            default: busy = busy;
        endcase
    end

    // State and transaction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= {IW{1'b0}};
            gnt_q     <= {IW{1'b0}};
            we_q      <= 1'b0;
            addr_q    <= {AW{1'b0}};
            wdata_q   <= {DW{1'b0}};
            rdata_q   <= {DW{1'b0}};
            err_q     <= 1'b0;
            wdt_cnt_q <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            wdt_cnt_q <= wdt_cnt_d;
        end
    end
endmodule
